seq_pattern_tx: RTL and testbench

SEQ_PATTERN_TX -- requirements
Module: seq_pattern_tx

---
 rtl/seq_pkg.sv | 17 +
 rtl/seq_shift_reg.sv | 42 ++++
 rtl/seq_pattern_tx.sv | 164 ++++++++++++++++
 tb/tb_seq_pattern_tx.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared definitions for the serial pattern transmitter.
//   state_e  : FSM state encoding (IDLE/SHIFT/GAP/DONE)
//   DefPatW  : default pattern length in bits
//   DefRepW  : default width of the repeat-count input
package seq_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StShift = 2'b01,
    StGap   = 2'b10,
    StDone  = 2'b11
  } state_e;

  localparam int unsigned DefPatW = 8;
  localparam int unsigned DefRepW = 4;

endpackage

// File: rtl/seq_shift_reg.sv
// Loadable MSB-first shift register.
// Ports:
//   clk      : rising-edge clock
//   rst      : asynchronous active-high reset, clears the register
//   load     : load data_in (has priority over shift)
//   shift    : shift left by one, zero fill
//   data_in  : parallel load value
//   msb_out  : current most significant bit
module seq_shift_reg #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] data_in,
  output logic         msb_out
);

  logic [W-1:0] sr_q;
  logic [W-1:0] sr_d;

  always_comb begin
    sr_d = sr_q;
    if (load) begin
      sr_d = data_in;
    end else if (shift) begin
      sr_d = {sr_q[W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign msb_out = sr_q[W-1];

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends a captured PAT_W-bit pattern MSB first,
// Repeat+1 times, with one idle gap cycle between frames and a Done pulse at
// the end.
// Optional feature: define SEQ_TX_PARITY_EN to append an even-parity bit to
// every frame.
// Ports:
//   CLK     : rising-edge clock
//   RST     : asynchronous active-high reset
//   Start   : transmit request, accepted only while Ready=1
//   Pattern : frame bits, captured on acceptance
//   Repeat  : extra frame count, captured on acceptance
//   Ready   : high only in IDLE
//   Out1    : registered serial data
//   Valid   : registered, high while Out1 carries a frame bit
//   Done    : registered one-cycle pulse after the last frame
module seq_pattern_tx
  import seq_pkg::*;
#(
  parameter int unsigned PAT_W = DefPatW,
  parameter int unsigned REP_W = DefRepW
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Start,
  input  logic [PAT_W-1:0] Pattern,
  input  logic [REP_W-1:0] Repeat,
  output logic             Ready,
  output logic             Out1,
  output logic             Valid,
  output logic             Done
);

`ifdef SEQ_TX_PARITY_EN
  localparam int unsigned FrameLen = PAT_W + 1;
`else
  localparam int unsigned FrameLen = PAT_W;
`endif
  localparam int unsigned CntW = $clog2(FrameLen + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(FrameLen);
`ifdef SEQ_TX_PARITY_EN
  localparam logic [CntW-1:0] LastDataCnt = CntW'(PAT_W);
`endif

  state_e           state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [REP_W-1:0] rep_q, rep_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             out1_q, out1_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;

  logic             sr_load;
  logic             sr_shift;
  logic [PAT_W-1:0] sr_din;
  logic             sr_msb;

  // The MSB goes straight to Out1 on load, so the shift register is loaded
  // pre-shifted and its MSB is always the next bit to emit.
  seq_shift_reg #(
    .W (PAT_W)
  ) u_shift_reg (
    .clk     (CLK),
    .rst     (RST),
    .load    (sr_load),
    .shift   (sr_shift),
    .data_in (sr_din),
    .msb_out (sr_msb)
  );

  always_comb begin
    state_d  = state_q;
    pat_d    = pat_q;
    rep_d    = rep_q;
    cnt_d    = cnt_q;
    out1_d   = 1'b0;
    valid_d  = 1'b0;
    done_d   = 1'b0;
    sr_load  = 1'b0;
    sr_shift = 1'b0;
    sr_din   = {pat_q[PAT_W-2:0], 1'b0};

    unique case (state_q)
      StIdle: begin
        if (Start) begin
          pat_d   = Pattern;
          rep_d   = Repeat;
          sr_load = 1'b1;
          sr_din  = {Pattern[PAT_W-2:0], 1'b0};
          out1_d  = Pattern[PAT_W-1];
          valid_d = 1'b1;
          cnt_d   = CntW'(1);
          state_d = StShift;
        end
      end

      // cnt_q counts bits already placed on Out1 in this frame.
      StShift: begin
        if (cnt_q == LastCnt) begin
          cnt_d = '0;
          if (rep_q != '0) begin
            state_d = StGap;
          end else begin
            state_d = StDone;
            done_d  = 1'b1;
          end
`ifdef SEQ_TX_PARITY_EN
        end else if (cnt_q == LastDataCnt) begin
          out1_d  = ^pat_q;
          valid_d = 1'b1;
          cnt_d   = cnt_q + 1'b1;
`endif
        end else begin
          out1_d   = sr_msb;
          valid_d  = 1'b1;
          sr_shift = 1'b1;
          cnt_d    = cnt_q + 1'b1;
        end
      end

      StGap: begin
        rep_d   = rep_q - 1'b1;
        sr_load = 1'b1;
        out1_d  = pat_q[PAT_W-1];
        valid_d = 1'b1;
        cnt_d   = CntW'(1);
        state_d = StShift;
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= StIdle;
      pat_q   <= '0;
      rep_q   <= '0;
      cnt_q   <= '0;
      out1_q  <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      rep_q   <= rep_d;
      cnt_q   <= cnt_d;
      out1_q  <= out1_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign Ready = (state_q == StIdle);
  assign Out1  = out1_q;
  assign Valid = valid_q;
  assign Done  = done_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Self-checking bench for seq_pattern_tx (PAT_W=8, REP_W=4).
// Honours SEQ_TX_PARITY_EN when defined for the build.
module tb_seq_pattern_tx;

  localparam int PW = 8;
  localparam int RW = 4;
`ifdef SEQ_TX_PARITY_EN
  localparam int FLEN = PW + 1;
`else
  localparam int FLEN = PW;
`endif

  logic          CLK = 1'b0;
  logic          RST;
  logic          Start;
  logic [PW-1:0] Pattern;
  logic [RW-1:0] Repeat;
  logic          Ready, Out1, Valid, Done;

  int checks = 0;
  int errors = 0;

  // Expected {Out1, Valid, Done, Ready} per cycle after acceptance.
  logic [3:0] exp_q[$];

  seq_pattern_tx #(
    .PAT_W (PW),
    .REP_W (RW)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .Start   (Start),
    .Pattern (Pattern),
    .Repeat  (Repeat),
    .Ready   (Ready),
    .Out1    (Out1),
    .Valid   (Valid),
    .Done    (Done)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  // Reference waveform from the frame rules: bits MSB first, optional parity,
  // a gap between frames, one Done cycle, then idle.
  task automatic build_exp(input logic [PW-1:0] p, input int r);
    exp_q.delete();
    for (int f = 0; f <= r; f++) begin
      for (int b = PW - 1; b >= 0; b--) exp_q.push_back({p[b], 3'b100});
`ifdef SEQ_TX_PARITY_EN
      exp_q.push_back({^p, 3'b100});
`endif
      if (f < r) exp_q.push_back(4'b0000);
    end
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0001);
  endtask

  // Starts a transmission from IDLE and checks every cycle up to the idle
  // cycle after Done. junk=1 scrambles inputs (incl. Start) while busy.
  task automatic run_frame(input string name, input logic [PW-1:0] p, input int r,
                           input bit junk, output int done_at);
    done_at = -1;
    build_exp(p, r);
    check({name, "_ready_pre"}, Ready, 1'b1);
    Start   = 1'b1;
    Pattern = p;
    Repeat  = RW'(r);
    tick;
    for (int i = 0; i < exp_q.size(); i++) begin
      check(name, {Out1, Valid, Done, Ready}, exp_q[i]);
      if (Done && done_at < 0) done_at = i + 1;
      if (i < exp_q.size() - 1) begin
        Start   = junk ? 1'($urandom) : 1'b0;
        Pattern = PW'($urandom);
        Repeat  = RW'($urandom);
        tick;
      end else begin
        Start = 1'b0;
      end
    end
  endtask

  typedef struct {
    string         name;
    logic [PW-1:0] pat;
    int            rep;
    bit            junk;
    int            done_np;  // Start-to-Done cycles without parity
    int            done_p;   // Start-to-Done cycles with parity
  } vec_t;

  vec_t vecs[$];

  initial begin
    int d;
    int exp_d;
    logic [PW-1:0] rp;
    int rr;

    vecs.push_back('{"b2_r0",  8'hB2, 0,  1'b0, 9,   10});
    vecs.push_back('{"f0_r2",  8'hF0, 2,  1'b0, 27,  30});
    vecs.push_back('{"aa_ign", 8'hAA, 0,  1'b1, 9,   10});
    vecs.push_back('{"07_r0",  8'h07, 0,  1'b0, 9,   10});
    vecs.push_back('{"00_r1",  8'h00, 1,  1'b1, 18,  20});
    vecs.push_back('{"ff_r15", 8'hFF, 15, 1'b1, 144, 160});

    RST     = 1'b1;
    Start   = 1'b0;
    Pattern = '0;
    Repeat  = '0;
    #1;
    check("reset_outs", {Out1, Valid, Done, Ready}, 4'b0001);
    tick;
    tick;
    RST = 1'b0;
    check("post_reset", {Out1, Valid, Done, Ready}, 4'b0001);

    foreach (vecs[k]) begin
      run_frame(vecs[k].name, vecs[k].pat, vecs[k].rep, vecs[k].junk, d);
`ifdef SEQ_TX_PARITY_EN
      check({vecs[k].name, "_done_at"}, d, vecs[k].done_p);
`else
      check({vecs[k].name, "_done_at"}, d, vecs[k].done_np);
`endif
    end

    // Reset in cycle 4 of an 8'hFF frame.
    Start   = 1'b1;
    Pattern = 8'hFF;
    Repeat  = 4'd0;
    tick;
    Start = 1'b0;
    tick;
    tick;
    tick;
    check("ff_cycle4", {Out1, Valid, Done, Ready}, 4'b1100);
    #2 RST = 1'b1;
    #1 check("rst_async", {Out1, Valid, Done, Ready}, 4'b0001);
    tick;
    RST = 1'b0;
    for (int i = 0; i < 12; i++) begin
      check("rst_no_done", {Out1, Valid, Done, Ready}, 4'b0001);
      tick;
    end

    // Acceptance on the first edge after reset release.
    RST = 1'b1;
    tick;
    RST = 1'b0;
    run_frame("c3_after_rst", 8'hC3, 1, 1'b0, d);
    check("c3_done_at", d, 2 * FLEN + 2);

    // Start held high: back-to-back frames, one DONE and one IDLE between.
    Start   = 1'b1;
    Pattern = 8'h01;
    Repeat  = 4'd0;
    tick;
    for (int f = 0; f < 2; f++) begin
      build_exp(8'h01, 0);
      for (int i = 0; i < exp_q.size(); i++) begin
        check("b2b", {Out1, Valid, Done, Ready}, exp_q[i]);
        tick;
      end
    end
    Start = 1'b0;
    for (int k = 0; k < 40 && !Ready; k++) tick;
    check("b2b_drain", Ready, 1'b1);

    // Randomised frames against the reference waveform.
    for (int n = 0; n < 30; n++) begin
      rp = PW'($urandom);
      rr = ($urandom_range(0, 7) == 0) ? 15 : int'($urandom_range(0, 3));
      run_frame("rand", rp, rr, 1'($urandom), d);
      exp_d = (rr + 1) * FLEN + rr + 1;
      check("rand_done_at", d, exp_d);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
